// File: rtl/tm_player_pkg.sv
// Shared types and constants for the Tsetlin-machine vector player.
// The optional toggle counter is enabled with TM_PLAYER_TOGGLE_CNT_EN.
package tm_player_pkg;

  localparam int unsigned DefInW   = 62;
  localparam int unsigned DefOutW  = 62;
  localparam int unsigned DefDepth = 16;
  localparam int unsigned DefHoldW = 8;

  localparam int unsigned         ToggleW   = 32;
  localparam logic [ToggleW-1:0] ToggleMax = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    StIdle,
    StApply,
    StHold,
    StCapture,
    StFinish
  } state_e;

endpackage

// File: rtl/tm_vector_mem.sv
// Vector store for the player: synchronous write, combinational read, no reset.
module tm_vector_mem
  import tm_player_pkg::*;
#(
  parameter int unsigned IN_W  = DefInW,
  parameter int unsigned DEPTH = DefDepth,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [IN_W-1:0] wdata_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [IN_W-1:0] rdata_o
);

  logic [IN_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tm_vector_player.sv
// Plays preloaded vectors into the netlist, holds each for a programmable time and captures outputs.
// Define TM_PLAYER_TOGGLE_CNT_EN to build the saturating output toggle counter.
module tm_vector_player
  import tm_player_pkg::*;
#(
  parameter int unsigned IN_W   = DefInW,
  parameter int unsigned OUT_W  = DefOutW,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned HOLD_W = DefHoldW,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned NW    = AW + 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cfg_we_i,
  input  logic [AW-1:0]      cfg_addr_i,
  input  logic [IN_W-1:0]    cfg_wdata_i,
  input  logic [NW-1:0]      cfg_num_vec_i,
  input  logic [HOLD_W-1:0]  cfg_hold_i,
  input  logic               start_i,
  input  logic               abort_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [IN_W-1:0]    dut_in_o,
  input  logic [OUT_W-1:0]   dut_out_i,
  output logic               cap_valid_o,
  output logic [AW-1:0]      cap_idx_o,
  output logic [OUT_W-1:0]   cap_data_o,
  output logic [ToggleW-1:0] toggle_cnt_o
);

  state_e             state_q, state_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [NW-1:0]      num_q, num_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [HOLD_W-1:0]  hcnt_q, hcnt_d;
  logic [IN_W-1:0]    dut_in_q, dut_in_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cap_valid_q, cap_valid_d;
  logic [AW-1:0]      cap_idx_q, cap_idx_d;
  logic [OUT_W-1:0]   cap_data_q, cap_data_d;

  logic [IN_W-1:0]    mem_rdata;
  logic [NW-1:0]      num_sat;
  logic               last_vec;
  logic               start_ok;

  // The memory is frozen while a run is in flight.
  tm_vector_mem #(
    .IN_W  (IN_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (cfg_we_i && !busy_q),
    .waddr_i (cfg_addr_i),
    .wdata_i (cfg_wdata_i),
    .raddr_i (idx_q),
    .rdata_o (mem_rdata)
  );

  assign num_sat  = (cfg_num_vec_i > NW'(DEPTH)) ? NW'(DEPTH) : cfg_num_vec_i;
  assign last_vec = ({1'b0, idx_q} == (num_q - NW'(1)));
  assign start_ok = (state_q == StIdle) && start_i;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    num_d       = num_q;
    hold_d      = hold_q;
    hcnt_d      = hcnt_q;
    dut_in_d    = dut_in_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cap_valid_d = 1'b0;
    cap_idx_d   = cap_idx_q;
    cap_data_d  = cap_data_q;

    if ((state_q != StIdle) && abort_i) begin
      state_d  = StIdle;
      dut_in_d = '0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            num_d   = num_sat;
            hold_d  = cfg_hold_i;
            idx_d   = '0;
            busy_d  = 1'b1;
            state_d = (num_sat == '0) ? StFinish : StApply;
          end
        end
        StApply: begin
          dut_in_d = mem_rdata;
          hcnt_d   = hold_q;
          state_d  = StHold;
        end
        StHold: begin
          if (hcnt_q == '0) begin
            state_d = StCapture;
          end else begin
            hcnt_d = hcnt_q - HOLD_W'(1);
          end
        end
        StCapture: begin
          cap_valid_d = 1'b1;
          cap_idx_d   = idx_q;
          cap_data_d  = dut_out_i;
          if (last_vec) begin
            state_d = StFinish;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = StApply;
          end
        end
        StFinish: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      num_q       <= '0;
      hold_q      <= '0;
      hcnt_q      <= '0;
      dut_in_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cap_valid_q <= 1'b0;
      cap_idx_q   <= '0;
      cap_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      num_q       <= num_d;
      hold_q      <= hold_d;
      hcnt_q      <= hcnt_d;
      dut_in_q    <= dut_in_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cap_valid_q <= cap_valid_d;
      cap_idx_q   <= cap_idx_d;
      cap_data_q  <= cap_data_d;
    end
  end

`ifdef TM_PLAYER_TOGGLE_CNT_EN
  localparam int unsigned PopW = $clog2(OUT_W + 1);
  localparam int unsigned SumW = ToggleW + 1;

  logic [OUT_W-1:0]   prev_q;
  logic [ToggleW-1:0] toggle_q;
  logic [OUT_W-1:0]   diff;
  logic [PopW-1:0]    pop;
  logic [SumW-1:0]    sum;

  assign diff = dut_out_i ^ prev_q;

  always_comb begin
    pop = '0;
    for (int i = 0; i < OUT_W; i++) begin
      pop = pop + PopW'(diff[i]);
    end
  end

  assign sum = {1'b0, toggle_q} + SumW'(pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q   <= '0;
      toggle_q <= '0;
    end else if (start_ok) begin
      prev_q   <= '0;
      toggle_q <= '0;
    end else if ((state_q == StCapture) && !abort_i) begin
      prev_q   <= dut_out_i;
      toggle_q <= sum[ToggleW] ? ToggleMax : sum[ToggleW-1:0];
    end
  end

  assign toggle_cnt_o = toggle_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
  assign toggle_cnt_o    = '0;
`endif

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign dut_in_o    = dut_in_q;
  assign cap_valid_o = cap_valid_q;
  assign cap_idx_o   = cap_idx_q;
  assign cap_data_o  = cap_data_q;

endmodule

// File: tb/tb_tm_vector_player.sv
// Directed bench for tm_vector_player with a combinational XOR loopback standing in for the netlist.
module tb_tm_vector_player;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [61:0] cfg_wdata = '0;
  logic [4:0]  cfg_num_vec = '0;
  logic [7:0]  cfg_hold = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, cap_valid;
  logic [61:0] dut_in, dut_out, cap_data;
  logic [3:0]  cap_idx;
  logic [31:0] toggle_cnt;

  localparam logic [61:0] Mask = 62'h0AAA_5555_1234_0F0F;
  logic [61:0] lb_mask = Mask;
  logic [61:0] mdl [16];

  assign dut_out = dut_in ^ lb_mask;

  tm_vector_player dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .cfg_we_i      (cfg_we),
    .cfg_addr_i    (cfg_addr),
    .cfg_wdata_i   (cfg_wdata),
    .cfg_num_vec_i (cfg_num_vec),
    .cfg_hold_i    (cfg_hold),
    .start_i       (start),
    .abort_i       (abort),
    .busy_o        (busy),
    .done_o        (done),
    .dut_in_o      (dut_in),
    .dut_out_i     (dut_out),
    .cap_valid_o   (cap_valid),
    .cap_idx_o     (cap_idx),
    .cap_data_o    (cap_data),
    .toggle_cnt_o  (toggle_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cap_cyc[$];
  int cap_ix[$];
  logic [61:0] cap_dt[$];
  int done_cnt;
  int done_cyc;
  int cnt_a, cnt_b;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [61:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a[3:0];
    cfg_wdata = d;
    tick();
    cfg_we    = 1'b0;
    mdl[a]    = d;
  endtask

  task automatic go(input int n, input int h);
    cfg_num_vec = n[4:0];
    cfg_hold    = h[7:0];
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  // Cycle numbers are counted from the first state after the start edge.
  task automatic run(input int budget);
    cap_cyc.delete();
    cap_ix.delete();
    cap_dt.delete();
    done_cnt = 0;
    done_cyc = -1;
    for (int c = 1; c <= budget; c++) begin
      tick();
      if (cap_valid) begin
        cap_cyc.push_back(c);
        cap_ix.push_back(int'(cap_idx));
        cap_dt.push_back(cap_data);
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (!busy) break;
    end
    check("run_terminates", 64'(busy), 64'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_cap_valid", 64'(cap_valid), 0);
    check("rst_cap_idx", 64'(cap_idx), 0);
    check("rst_cap_data", 64'(cap_data), 0);
    check("rst_dut_in", 64'(dut_in), 0);
    check("rst_toggle", 64'(toggle_cnt), 0);
    rst_ni = 1'b1;
    tick();

    // Three vectors, no extra hold
    wr(0, 62'd1);
    wr(1, 62'd2);
    wr(2, 62'd3);
    go(3, 0);
    check("t1_busy_after_start", 64'(busy), 1);
    run(50);
    check("t1_ncap", 64'(cap_cyc.size()), 3);
    for (int i = 0; i < cap_cyc.size() && i < 3; i++) begin
      check($sformatf("t1_cyc%0d", i), 64'(cap_cyc[i]), 64'(3 * (i + 1)));
      check($sformatf("t1_idx%0d", i), 64'(cap_ix[i]), 64'(i));
      check($sformatf("t1_data%0d", i), 64'(cap_dt[i]), 64'(mdl[i] ^ Mask));
    end
    check("t1_done_cnt", 64'(done_cnt), 1);
    check("t1_done_cyc", 64'(done_cyc), 10);
`ifndef TM_PLAYER_TOGGLE_CNT_EN
    check("t1_toggle_tied", 64'(toggle_cnt), 0);
`endif

    // Zero-length run
    go(0, 0);
    run(10);
    check("t2_ncap", 64'(cap_cyc.size()), 0);
    check("t2_done_cnt", 64'(done_cnt), 1);
    check("t2_done_cyc", 64'(done_cyc), 1);
    check("t2_dut_in_kept", 64'(dut_in), 64'(mdl[2]));

    // Count saturates at DEPTH
    for (int i = 3; i < 16; i++) wr(i, 62'h0F0F_0000_0000 | 62'(i * 37));
    go(20, 2);
    run(200);
    check("t3_ncap", 64'(cap_cyc.size()), 16);
    for (int i = 0; i < cap_cyc.size() && i < 16; i++) begin
      check($sformatf("t3_cyc%0d", i), 64'(cap_cyc[i]), 64'(5 * (i + 1)));
      check($sformatf("t3_idx%0d", i), 64'(cap_ix[i]), 64'(i));
      check($sformatf("t3_data%0d", i), 64'(cap_dt[i]), 64'(mdl[i] ^ Mask));
    end
    check("t3_done_cyc", 64'(done_cyc), 81);

    // Writes and start while busy are ignored
    go(3, 2);
    cfg_we      = 1'b1;
    cfg_addr    = 4'd0;
    cfg_wdata   = 62'hDEAD;
    cfg_num_vec = 5'd1;
    start       = 1'b1;
    tick();
    cfg_we = 1'b0;
    start  = 1'b0;
    run(100);
    check("t4_ncap", 64'(cap_cyc.size()), 3);
    check("t4_done_cyc", 64'(done_cyc), 15);
    check("t4_done_cnt", 64'(done_cnt), 1);
    go(1, 0);
    run(20);
    check("t4_ncap_b", 64'(cap_cyc.size()), 1);
    check("t4_mem0_kept", 64'(cap_data), 64'(mdl[0] ^ Mask));

    // Abort during HOLD of vector 1
    go(3, 3);
    cnt_a = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (cap_valid) cnt_a++;
    end
    check("t5_caps_before_abort", 64'(cnt_a), 1);
    check("t5_busy_before_abort", 64'(busy), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_busy", 64'(busy), 0);
    check("t5_dut_in", 64'(dut_in), 0);
    check("t5_cap_valid", 64'(cap_valid), 0);
    cnt_a = 0;
    cnt_b = 0;
    for (int c = 0; c < 5; c++) begin
      if (done) cnt_a++;
      if (cap_valid) cnt_b++;
      tick();
    end
    check("t5_no_done", 64'(cnt_a), 0);
    check("t5_no_cap", 64'(cnt_b), 0);
    go(1, 0);
    run(20);
    check("t5_restart_ncap", 64'(cap_cyc.size()), 1);
    check("t5_restart_idx", 64'(cap_idx), 0);
    check("t5_restart_data", 64'(cap_data), 64'(mdl[0] ^ Mask));
    check("t5_restart_done", 64'(done_cnt), 1);

`ifdef TM_PLAYER_TOGGLE_CNT_EN
    // Outputs 0, F, 0 give 0 + 4 + 4 toggles
    lb_mask = '0;
    wr(0, 62'h0);
    wr(1, 62'hF);
    wr(2, 62'h0);
    go(3, 0);
    run(50);
    check("t6_toggle", 64'(toggle_cnt), 8);
    lb_mask = Mask;
`endif

    // Reset mid-run clears everything at once
    go(3, 0);
    for (int c = 0; c < 4; c++) tick();
    check("t7_busy_before_rst", 64'(busy), 1);
    rst_ni = 1'b0;
    #1;
    check("t7_busy", 64'(busy), 0);
    check("t7_done", 64'(done), 0);
    check("t7_cap_valid", 64'(cap_valid), 0);
    check("t7_cap_idx", 64'(cap_idx), 0);
    check("t7_cap_data", 64'(cap_data), 0);
    check("t7_dut_in", 64'(dut_in), 0);
    check("t7_toggle", 64'(toggle_cnt), 0);
    rst_ni = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
